// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Purpose  : Shared types for the N-way cache controller: the controller
//             state encoding and the latched CPU operation.
//  Ports    : none (package)
//  Revision : 1.0  initial N-way release
// ============================================================================
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      WB_REQ    = 3'd2,
      WB_WAIT   = 3'd3,
      FILL_REQ  = 3'd4,
      FILL_WAIT = 3'd5,
      INSTALL   = 3'd6,
      ERROR     = 3'd7
   } cache_state_t;

   typedef enum logic [0:0] {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } cache_op_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_victim_sel.sv
`default_nettype none
// ============================================================================
//  Module   : cache_victim_sel
//  Purpose  : Combinational way decode for the addressed set.
//             - victim_idx : lowest-index invalid way, else the LRU way
//             - hit_idx    : index of the (single) matching way
//             - hit_any    : at least one way matched
//             - hit_multi  : more than one way matched (tag corruption)
//  Ports    : hit_way, is_valid [NUM_WAYS] in; lru_victim [WAY_W] in;
//             victim_idx, hit_idx [WAY_W] out; hit_any, hit_multi out
//  Revision : 1.0  initial N-way release
// ============================================================================
module cache_victim_sel #(
   parameter int NUM_WAYS = 4,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0] hit_way,
   input  logic [NUM_WAYS-1:0] is_valid,
   input  logic [WAY_W-1:0]    lru_victim,
   output logic [WAY_W-1:0]    victim_idx,
   output logic [WAY_W-1:0]    hit_idx,
   output logic                hit_any,
   output logic                hit_multi
);

   logic [WAY_W:0] hit_cnt;

   always_comb begin
      victim_idx = lru_victim;
      hit_idx    = '0;
      hit_cnt    = '0;
      // Walk from the top down so the lowest-index invalid way wins.
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!is_valid[i]) begin
            victim_idx = WAY_W'(i);
         end
         if (hit_way[i]) begin
            hit_idx = WAY_W'(i);
            hit_cnt = hit_cnt + (WAY_W+1)'(1);
         end
      end
      hit_any   = (hit_cnt != '0);
      hit_multi = (hit_cnt > (WAY_W+1)'(1));
   end

endmodule : cache_victim_sel
`default_nettype wire

// File: rtl/cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
//  Module   : cache_ctrl_nway
//  Purpose  : Control FSM for an N-way set-associative write-back,
//             write-allocate cache. Sequences lookup, victim writeback, line
//             fill and install; all outputs are registered.
//  Ports    : clk, rst (async, active high)
//             CPU  : cpu_read, cpu_write in; cpu_rd_valid, cpu_wr_done out
//             Tags : hit_way, is_valid, is_dirty, lru_victim in
//             Array: load_data, load_tag, data_in_select, set/write_valid,
//                    set/write_dirty, lru_update, lru_way, wb_way out
//             Mem  : mem_ack in; mem_read, mem_write out
//             Misc : busy, error out
//  Revision : 1.0  initial N-way release
// ============================================================================
module cache_ctrl_nway
   import cache_pkg::*;
#(
   parameter int NUM_WAYS    = 4,
   parameter int WAY_W       = $clog2(NUM_WAYS),
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cpu_read,
   input  logic                cpu_write,
   input  logic [NUM_WAYS-1:0] hit_way,
   input  logic [NUM_WAYS-1:0] is_valid,
   input  logic [NUM_WAYS-1:0] is_dirty,
   input  logic [WAY_W-1:0]    lru_victim,
   input  logic                mem_ack,
   output logic                busy,
   output logic                cpu_rd_valid,
   output logic                cpu_wr_done,
   output logic [NUM_WAYS-1:0] load_data,
   output logic [NUM_WAYS-1:0] load_tag,
   output logic                data_in_select,
   output logic [NUM_WAYS-1:0] set_valid,
   output logic [NUM_WAYS-1:0] write_valid,
   output logic [NUM_WAYS-1:0] set_dirty,
   output logic [NUM_WAYS-1:0] write_dirty,
   output logic                lru_update,
   output logic [WAY_W-1:0]    lru_way,
   output logic                mem_read,
   output logic                mem_write,
   output logic [WAY_W-1:0]    wb_way,
   output logic                error
);

   localparam int                  CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]    TMO_MAX = CNT_W'(MEM_TIMEOUT);
   localparam logic [NUM_WAYS-1:0] WAY0_OH = NUM_WAYS'(1);

   cache_state_t        state_q, state_d;
   cache_op_t           op_q, op_d;
   logic [WAY_W-1:0]    victim_q, victim_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                cpu_rd_valid_q, cpu_rd_valid_d;
   logic                cpu_wr_done_q, cpu_wr_done_d;
   logic [NUM_WAYS-1:0] load_data_q, load_data_d;
   logic [NUM_WAYS-1:0] load_tag_q, load_tag_d;
   logic                data_in_select_q, data_in_select_d;
   logic [NUM_WAYS-1:0] set_valid_q, set_valid_d;
   logic [NUM_WAYS-1:0] write_valid_q, write_valid_d;
   logic [NUM_WAYS-1:0] set_dirty_q, set_dirty_d;
   logic [NUM_WAYS-1:0] write_dirty_q, write_dirty_d;
   logic                lru_update_q, lru_update_d;
   logic [WAY_W-1:0]    lru_way_q, lru_way_d;
   logic                mem_read_q, mem_read_d;
   logic                mem_write_q, mem_write_d;
   logic [WAY_W-1:0]    wb_way_q, wb_way_d;
   logic                error_q, error_d;

   logic [WAY_W-1:0]    sel_victim;
   logic [WAY_W-1:0]    hit_idx;
   logic                hit_any;
   logic                hit_multi;
   logic                req_held;
   logic [NUM_WAYS-1:0] victim_oh;

   cache_victim_sel #(
      .NUM_WAYS (NUM_WAYS),
      .WAY_W    (WAY_W)
   ) u_victim_sel (
      .hit_way    (hit_way),
      .is_valid   (is_valid),
      .lru_victim (lru_victim),
      .victim_idx (sel_victim),
      .hit_idx    (hit_idx),
      .hit_any    (hit_any),
      .hit_multi  (hit_multi)
   );

   // The request that started this access must still be present for the CPU
   // to receive a completion pulse; a dropped request finishes silently.
   assign req_held  = (op_q == OP_WRITE) ? cpu_write : cpu_read;
   assign victim_oh = WAY0_OH << victim_q;

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      victim_d         = victim_q;
      cnt_d            = cnt_q;
      cpu_rd_valid_d   = 1'b0;
      cpu_wr_done_d    = 1'b0;
      load_data_d      = '0;
      load_tag_d       = '0;
      data_in_select_d = 1'b0;
      set_valid_d      = '0;
      write_valid_d    = '0;
      set_dirty_d      = '0;
      write_dirty_d    = '0;
      lru_update_d     = 1'b0;
      lru_way_d        = lru_way_q;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      wb_way_d         = wb_way_q;
      error_d          = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_write) begin
               op_d    = OP_WRITE;
               state_d = LOOKUP;
            end else if (cpu_read) begin
               op_d    = OP_READ;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit_multi) begin
               state_d = ERROR;
            end else if (!req_held) begin
               state_d = IDLE;
            end else if (hit_any) begin
               lru_update_d = 1'b1;
               lru_way_d    = hit_idx;
               if (op_q == OP_WRITE) begin
                  // hit_way is one-hot here, so it doubles as the way strobe.
                  load_data_d   = hit_way;
                  set_dirty_d   = hit_way;
                  write_dirty_d = hit_way;
                  cpu_wr_done_d = 1'b1;
               end else begin
                  cpu_rd_valid_d = 1'b1;
               end
               state_d = IDLE;
            end else begin
               victim_d = sel_victim;
               if (is_valid[sel_victim] && is_dirty[sel_victim]) begin
                  state_d = WB_REQ;
               end else begin
                  state_d = FILL_REQ;
               end
            end
         end
         WB_REQ: begin
            mem_write_d = 1'b1;
            wb_way_d    = victim_q;
            cnt_d       = '0;
            state_d     = WB_WAIT;
         end
         WB_WAIT: begin
            if (mem_ack) begin
               state_d = FILL_REQ;
            end else if (cnt_q == TMO_MAX) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         FILL_REQ: begin
            mem_read_d = 1'b1;
            cnt_d      = '0;
            state_d    = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (mem_ack) begin
               state_d = INSTALL;
            end else if (cnt_q == TMO_MAX) begin
               state_d = ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         INSTALL: begin
            // Clean fill; a pending write merges on the following lookup hit.
            data_in_select_d = 1'b1;
            load_data_d      = victim_oh;
            load_tag_d       = victim_oh;
            set_valid_d      = victim_oh;
            write_valid_d    = victim_oh;
            write_dirty_d    = victim_oh;
            state_d          = LOOKUP;
         end
         ERROR: begin
            error_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         op_q             <= OP_READ;
         victim_q         <= '0;
         cnt_q            <= '0;
         cpu_rd_valid_q   <= 1'b0;
         cpu_wr_done_q    <= 1'b0;
         load_data_q      <= '0;
         load_tag_q       <= '0;
         data_in_select_q <= 1'b0;
         set_valid_q      <= '0;
         write_valid_q    <= '0;
         set_dirty_q      <= '0;
         write_dirty_q    <= '0;
         lru_update_q     <= 1'b0;
         lru_way_q        <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         wb_way_q         <= '0;
         error_q          <= 1'b0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         victim_q         <= victim_d;
         cnt_q            <= cnt_d;
         cpu_rd_valid_q   <= cpu_rd_valid_d;
         cpu_wr_done_q    <= cpu_wr_done_d;
         load_data_q      <= load_data_d;
         load_tag_q       <= load_tag_d;
         data_in_select_q <= data_in_select_d;
         set_valid_q      <= set_valid_d;
         write_valid_q    <= write_valid_d;
         set_dirty_q      <= set_dirty_d;
         write_dirty_q    <= write_dirty_d;
         lru_update_q     <= lru_update_d;
         lru_way_q        <= lru_way_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         wb_way_q         <= wb_way_d;
         error_q          <= error_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign cpu_rd_valid   = cpu_rd_valid_q;
   assign cpu_wr_done    = cpu_wr_done_q;
   assign load_data      = load_data_q;
   assign load_tag       = load_tag_q;
   assign data_in_select = data_in_select_q;
   assign set_valid      = set_valid_q;
   assign write_valid    = write_valid_q;
   assign set_dirty      = set_dirty_q;
   assign write_dirty    = write_dirty_q;
   assign lru_update     = lru_update_q;
   assign lru_way        = lru_way_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign wb_way         = wb_way_q;
   assign error          = error_q;

endmodule : cache_ctrl_nway
`default_nettype wire

// File: tb/tb_cache_ctrl_nway.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_ctrl_nway
//  Purpose  : Self-checking bench for cache_ctrl_nway (4 ways, timeout 255).
//             Table of single-lookup transactions plus hand-written miss,
//             timeout and reset sequences.
//  Revision : 1.0  initial
// ============================================================================
module tb_cache_ctrl_nway;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_read, cpu_write, mem_ack;
   logic [3:0] hit_way, is_valid, is_dirty;
   logic [1:0] lru_victim;
   logic       busy, cpu_rd_valid, cpu_wr_done, data_in_select;
   logic [3:0] load_data, load_tag, set_valid, write_valid, set_dirty, write_dirty;
   logic       lru_update, mem_read, mem_write, error;
   logic [1:0] lru_way, wb_way;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cache_ctrl_nway #(.NUM_WAYS(4), .WAY_W(2), .MEM_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst),
      .cpu_read(cpu_read), .cpu_write(cpu_write),
      .hit_way(hit_way), .is_valid(is_valid), .is_dirty(is_dirty),
      .lru_victim(lru_victim), .mem_ack(mem_ack),
      .busy(busy), .cpu_rd_valid(cpu_rd_valid), .cpu_wr_done(cpu_wr_done),
      .load_data(load_data), .load_tag(load_tag), .data_in_select(data_in_select),
      .set_valid(set_valid), .write_valid(write_valid),
      .set_dirty(set_dirty), .write_dirty(write_dirty),
      .lru_update(lru_update), .lru_way(lru_way),
      .mem_read(mem_read), .mem_write(mem_write), .wb_way(wb_way),
      .error(error)
   );

   typedef struct {
      logic       rd;
      logic       wr;
      logic [3:0] hit;
      logic       rdv;
      logic       wrd;
      logic [3:0] ld;
      logic [3:0] sd;
      logic       lru;
      logic [1:0] way;
      logic       err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_read = 0; cpu_write = 0; mem_ack = 0;
      hit_way = 4'b0000; is_valid = 4'b1111; is_dirty = 4'b0000; lru_victim = 2'd0;
   endtask

   initial begin
      vecs[0] = '{rd:1, wr:0, hit:4'b0100, rdv:1, wrd:0, ld:4'b0000, sd:4'b0000, lru:1, way:2, err:0};
      vecs[1] = '{rd:1, wr:0, hit:4'b0001, rdv:1, wrd:0, ld:4'b0000, sd:4'b0000, lru:1, way:0, err:0};
      vecs[2] = '{rd:0, wr:1, hit:4'b1000, rdv:0, wrd:1, ld:4'b1000, sd:4'b1000, lru:1, way:3, err:0};
      vecs[3] = '{rd:1, wr:1, hit:4'b0010, rdv:0, wrd:1, ld:4'b0010, sd:4'b0010, lru:1, way:1, err:0};
      vecs[4] = '{rd:1, wr:0, hit:4'b0110, rdv:0, wrd:0, ld:4'b0000, sd:4'b0000, lru:0, way:0, err:1};
      vecs[5] = '{rd:0, wr:1, hit:4'b1001, rdv:0, wrd:0, ld:4'b0000, sd:4'b0000, lru:0, way:0, err:1};

      idle_inputs();
      rst = 1;
      tick();
      tick();
      chk("reset_busy", busy, 0);
      chk("reset_strobes", {cpu_rd_valid, cpu_wr_done, load_data, load_tag, mem_read,
                            mem_write, error, lru_update, wb_way, lru_way}, 0);
      rst = 0;
      tick();

      // ---------------- single-lookup transactions ----------------
      for (int v = 0; v < 6; v++) begin
         cpu_read = vecs[v].rd; cpu_write = vecs[v].wr; hit_way = vecs[v].hit;
         tick();
         chk($sformatf("v%0d_busy", v), busy, 1);
         tick();
         chk($sformatf("v%0d_rd_valid", v), cpu_rd_valid, vecs[v].rdv);
         chk($sformatf("v%0d_wr_done", v), cpu_wr_done, vecs[v].wrd);
         chk($sformatf("v%0d_load_data", v), load_data, vecs[v].ld);
         chk($sformatf("v%0d_set_dirty", v), set_dirty, vecs[v].sd);
         chk($sformatf("v%0d_write_dirty", v), write_dirty, vecs[v].sd);
         chk($sformatf("v%0d_lru_update", v), lru_update, vecs[v].lru);
         chk($sformatf("v%0d_dsel", v), data_in_select, 0);
         if (vecs[v].lru) chk($sformatf("v%0d_lru_way", v), lru_way, vecs[v].way);
         cpu_read = 0; cpu_write = 0; hit_way = 4'b0000;
         tick();
         chk($sformatf("v%0d_error", v), error, vecs[v].err);
         chk($sformatf("v%0d_idle", v), busy, 0);
         tick();
         chk($sformatf("v%0d_error_gone", v), error, 0);
      end

      // ---------------- write miss, invalid way 2 chosen ----------------
      // Way 2 is invalid (its dirty bit is meaningless), so no writeback.
      cpu_write = 1; is_valid = 4'b1011; is_dirty = 4'b0100; lru_victim = 2'd0;
      tick();                                // LOOKUP
      tick();                                // -> FILL_REQ
      chk("wm_no_memwr_a", mem_write, 0);
      tick();                                // -> FILL_WAIT
      chk("wm_mem_read", mem_read, 1);
      chk("wm_no_memwr_b", mem_write, 0);
      mem_ack = 1;
      tick();                                // -> INSTALL
      mem_ack = 0;
      chk("wm_mem_read_pulse", mem_read, 0);
      tick();                                // -> LOOKUP, install strobes
      chk("wm_inst_load_data", load_data, 4'b0100);
      chk("wm_inst_load_tag", load_tag, 4'b0100);
      chk("wm_inst_valid", {set_valid, write_valid}, 8'b0100_0100);
      chk("wm_inst_dirty", {set_dirty, write_dirty}, 8'b0000_0100);
      chk("wm_inst_dsel", data_in_select, 1);
      chk("wm_inst_no_done", cpu_wr_done, 0);
      hit_way = 4'b0100; is_valid = 4'b1111;
      tick();                                // merge hit
      chk("wm_merge_load_data", load_data, 4'b0100);
      chk("wm_merge_dirty", {set_dirty, write_dirty}, 8'b0100_0100);
      chk("wm_merge_dsel", data_in_select, 0);
      chk("wm_merge_done", cpu_wr_done, 1);
      chk("wm_merge_lru", {lru_update, lru_way}, 3'b1_10);
      idle_inputs();
      tick();
      chk("wm_idle", busy, 0);

      // ---------------- read miss, dirty LRU victim 1 ----------------
      cpu_read = 1; is_dirty = 4'b0010; lru_victim = 2'd1;
      tick();                                // LOOKUP
      tick();                                // -> WB_REQ
      tick();                                // -> WB_WAIT
      chk("rm_mem_write", mem_write, 1);
      chk("rm_wb_way", wb_way, 1);
      tick();
      chk("rm_mem_write_pulse", mem_write, 0);
      chk("rm_wait_busy", busy, 1);
      mem_ack = 1;
      tick();                                // -> FILL_REQ
      mem_ack = 0;
      chk("rm_no_read_yet", mem_read, 0);
      tick();                                // -> FILL_WAIT
      chk("rm_mem_read", mem_read, 1);
      mem_ack = 1;
      tick();                                // -> INSTALL
      mem_ack = 0;
      tick();                                // -> LOOKUP
      chk("rm_inst_load", {load_data, load_tag}, 8'b0010_0010);
      chk("rm_inst_clean", {set_dirty, write_dirty}, 8'b0000_0010);
      chk("rm_inst_valid", set_valid, 4'b0010);
      chk("rm_inst_no_rdv", cpu_rd_valid, 0);
      hit_way = 4'b0010;
      tick();
      chk("rm_rd_valid", cpu_rd_valid, 1);
      chk("rm_lru", {lru_update, lru_way}, 3'b1_01);
      chk("rm_no_load", load_data, 0);
      idle_inputs();
      tick();
      chk("rm_idle", busy, 0);

      // ---------------- fill timeout ----------------
      begin
         int waited;
         logic seen;
         cpu_read = 1; lru_victim = 2'd3;
         tick(); tick(); tick();             // FILL_WAIT entered, count 0
         cpu_read = 0;
         waited = 0; seen = 0;
         while (!seen && waited < 400) begin
            tick();
            waited++;
            if (error) seen = 1;
         end
         chk("tmo_error_seen", seen, 1);
         chk("tmo_latency", waited, 257);
         chk("tmo_idle", busy, 0);
         tick();
         chk("tmo_error_pulse", error, 0);
      end

      // ---------------- ack coincides with timeout: ack wins ----------------
      cpu_read = 1; lru_victim = 2'd3;
      tick(); tick(); tick();                // FILL_WAIT, count 0
      cpu_read = 0;                          // request dropped mid-miss
      for (int k = 0; k < 255; k++) tick();  // count now at the limit
      chk("race_still_busy", busy, 1);
      mem_ack = 1;
      tick();                                // -> INSTALL
      mem_ack = 0;
      chk("race_no_error", error, 0);
      tick();                                // -> LOOKUP, install way 3
      chk("race_install", load_data, 4'b1000);
      chk("race_no_error_b", error, 0);
      tick();                                // dropped request: silent IDLE
      chk("race_no_pulse", {cpu_rd_valid, cpu_wr_done, lru_update}, 0);
      chk("race_idle", busy, 0);

      // ---------------- async reset during WB_WAIT ----------------
      idle_inputs();
      cpu_read = 1; is_dirty = 4'b0001; lru_victim = 2'd0;
      tick(); tick(); tick();                // WB_WAIT
      chk("rst_pre_memwr", {mem_write, wb_way}, 3'b1_00);
      chk("rst_pre_busy", busy, 1);
      #2 rst = 1;
      #1;
      chk("rst_async_busy", busy, 0);
      chk("rst_async_outs", {mem_write, mem_read, error, load_data, cpu_rd_valid}, 0);
      idle_inputs();
      tick();
      rst = 0;
      tick();
      chk("rst_after_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cache_ctrl_nway
`default_nettype wire
